mdu_sched: RTL
==============

Name: mdu_sched

Overview:
- Multiply/divide sequencer that owns the HI/LO register pair.
- Executes mult/div with fixed multi-cycle latency, produces a busy flag, and raises a stall request for the decode/execute boundary.
- Sits beside the ALU in the E stage. The E stage reads hi/lo for mfhi/mflo, and the results flow down the pipeline through the existing E/M register.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset, sampled on posedge clk.
- start  in  1  launch md_op using op_a/op_b this cycle.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub.
- op_a  in  32  rs operand, already forwarded.
- op_b  in  32  rt operand, already forwarded.
- hi_we  in  1  mthi: write op_a to HI.
- lo_we  in  1  mtlo: write op_a to LO.
- md_use_D  in  1  the D-stage instruction is any MDU instruction (md op, mthi/mtlo, mfhi/mflo).
- busy  out  1  operation in flight.
- stall_req  out  1  combinational: (busy | start) & md_use_D.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset:
  - Single clock.
  - reset is synchronous and active-high: it acts only at posedge clk.
  - Reset values: busy=0, hi=0, lo=0, counter=0, pending results cleared.
  - stall_req follows its equation and reads 0 when all inputs are 0.
- FSM has two states:
  - IDLE: busy=0. If start=1 and md_op is a legal op, latch the op and operands, load counter = N-1, go to RUN.
  - RUN: busy=1; counter decrements each cycle. When counter==0 (and no reset), commit results to hi/lo and go to IDLE.
- N is MULT_CYCLES for mult-type ops and DIV_CYCLES for div-type ops.
- Timing contract: start sampled at edge T makes busy=1 for exactly N cycles after T. The new hi/lo and busy=0 appear together in the cycle after the last busy cycle. Implementations may compute early but must hide the results until commit.
- start with md_op=0, or while in RUN: ignored. The pipeline guarantees this never occurs in RUN; the block must not corrupt state if it does.
- hi_we/lo_we:
  - In IDLE, write op_a at the next edge; hi and lo may both be written the same cycle.
  - In RUN, ignored.
  - If start and hi_we/lo_we are asserted together in IDLE, start wins and the writes are dropped.
- Arithmetic:
  - mult/multu: 64-bit product of signed/unsigned operands; hi = [63:32], lo = [31:0].
  - div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
  - Divide by zero: still busy for DIV_CYCLES; hi/lo unchanged at commit.
  - madd/maddu/msub: {hi,lo} ± product modulo 2^64, using the hi/lo value at commit time.
- Reset while in RUN: abort the operation; next cycle busy=0, hi=lo=0; nothing is committed.
- stall_req is purely combinational. It stalls an MDU instruction in D both while an operation runs and in the cycle an op is issued from E.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: md_op 5/6/7 execute as madd (signed), maddu (unsigned), msub (signed) with MULT_CYCLES latency.
- Undefined: md_op 5..7 are illegal; start with them is ignored (stays IDLE, busy=0, hi/lo unchanged). No accumulate adder is instantiated.

Test Plan:
- Reset, then start mult with op_a=0xFFFFFFFE (-2), op_b=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- Start multu with 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles; hi_we pulsed mid-run is ignored.
- Start div with op_a=-7 (0xFFFFFFF9), op_b=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. A follow-up divu 7/0 leaves those values unchanged.
- With busy=1 and md_use_D=1 -> stall_req=1. With busy=0, start=1, md_use_D=1 -> stall_req=1. With md_use_D=0 -> stall_req=0.
- hi_we=1, lo_we=1, op_a=0x12345678 in IDLE -> both hi and lo equal 0x12345678 next cycle. Then start mult and assert reset in the 3rd busy cycle -> next cycle busy=0, hi=lo=0.
- With MDU_MADD_EN and hi=0, lo=10: madd 3x4 -> lo=22. Without the macro, the same start leaves busy=0 and lo=10.

Source files
------------

// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide sequencer owning HI/LO; fixed-latency mult/div with busy and stall request.
// Optional MDU_MADD_EN enables madd/maddu/msub accumulate ops.
`default_nettype none

module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] C_DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [3:0]  r_cnt;

  logic        w_legal, w_launch, w_commit, w_wr;
  logic [63:0] w_res;
  logic [63:0] w_sprod, w_uprod;
  logic signed [31:0] w_sa, w_sb, w_sq, w_sr;

  always_comb begin
    w_legal = 1'b0;
    case (md_op)
      3'd1, 3'd2, 3'd3, 3'd4: w_legal = 1'b1;
`ifdef MDU_MADD_EN
      3'd5, 3'd6, 3'd7:       w_legal = 1'b1;
`endif
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (start && w_legal) begin
        w_launch    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (r_cnt == 4'd0) begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Results are formed from latched operands and only become visible at commit.
  assign w_sprod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_uprod = {32'd0, r_a} * {32'd0, r_b};
  assign w_sa    = r_a;
  assign w_sb    = r_b;
  assign w_sq    = w_sa / w_sb;
  assign w_sr    = w_sa % w_sb;

  always_comb begin
    w_res = {r_hi, r_lo};
    w_wr  = 1'b1;
    case (r_op)
      3'd1: w_res = w_sprod;
      3'd2: w_res = w_uprod;
      3'd3: begin
        if (r_b == 32'd0)
          w_wr = 1'b0;
        else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF)
          w_res = {32'd0, 32'h8000_0000};
        else
          w_res = {w_sr, w_sq};
      end
      3'd4: begin
        if (r_b == 32'd0)
          w_wr = 1'b0;
        else
          w_res = {r_a % r_b, r_a / r_b};
      end
`ifdef MDU_MADD_EN
      3'd5: w_res = {r_hi, r_lo} + w_sprod;
      3'd6: w_res = {r_hi, r_lo} + w_uprod;
      3'd7: w_res = {r_hi, r_lo} - w_sprod;
`endif
      default: w_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= 3'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_cnt <= 4'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (w_launch) begin
        r_op  <= md_op;
        r_a   <= op_a;
        r_b   <= op_b;
        r_cnt <= (md_op == 3'd3 || md_op == 3'd4) ? C_DIV_LOAD : C_MULT_LOAD;
      end else if (r_state == S_RUN && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        if (w_wr) begin
          r_hi <= w_res[63:32];
          r_lo <= w_res[31:0];
        end
      end else if (r_state == S_IDLE && !start) begin
        if (hi_we) r_hi <= op_a;
        if (lo_we) r_lo <= op_a;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign stall_req = (busy | start) & md_use_D;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

`default_nettype wire
